// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C transaction arbiter.
//   cmd_op_t  - byte-level engine command encoding
//   state_t   - transaction FSM states
//   ERR_*     - response error codes
//   TIMEOUT_DEFAULT - default per-command watchdog limit (scl_4x cycles)
package i2c_pkg;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    OP_START_WR  = 3'd0,
    OP_WRITE     = 3'd1,
    OP_READ_NACK = 3'd2,
    OP_STOP      = 3'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_REG    = 3'd2,
    ST_DATA   = 3'd3,
    ST_RSTART = 3'd4,
    ST_READ   = 3'd5,
    ST_STOP   = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_DEV_NACK  = 2'b01;
  localparam logic [1:0] ERR_DATA_NACK = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

endpackage

// File: rtl/i2c_rr_arb2.sv
// i2c_rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n - clock and async active-low reset
//   en         - grant opportunity this cycle; pointer advances only when set
//   req[1:0]   - pending requests
//   gnt[1:0]   - one-hot grant (combinational)
//   gnt_id     - index of the granted requester
// The pointer remembers the last granted requester; it resets to 1 so that
// requester 0 wins the first tie.
module i2c_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last;

  always_comb begin
    gnt_id = 1'b0;
    unique case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = 1'b0;
    endcase
    gnt = (|req) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (en && (|req)) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: arbitrates two register-access requesters onto one
// byte-level I2C engine and sequences the full write/read transaction.
//   scl_4x, rst_n               - clock, async active-low reset
//   req_valid/ready/rw          - per-requester handshake and direction
//   req_dev_addr/reg_addr/wdata - packed per-requester fields (req1 in upper half)
//   rsp_valid/ready/id/rdata/err - response to the owning requester
//   cmd_valid/ready/op/byte     - command to the byte engine
//   cmd_done/done_nack/done_rdata - engine completion
//
// state  | meaning
// IDLE   | arbitrate; req_ready pulses one cycle after a grant
// ADDR   | START_WR {dev,0}
// REG    | WRITE reg_addr
// DATA   | WRITE wdata (write path)
// RSTART | START_WR {dev,1} (read path)
// READ   | READ_NACK, capture done_rdata
// STOP   | STOP, done_nack ignored
// RESP   | hold response until rsp_ready
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        scl_4x,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_rw,
  input  logic [13:0] req_dev_addr,
  input  logic [15:0] req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_byte,
  input  logic        cmd_done,
  input  logic        done_nack,
  input  logic [7:0]  done_rdata
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic            cmd_wait_q, cmd_wait_d;
  logic [WDW-1:0]  wdog_q, wdog_inc;
  logic            timeout_hit;
  logic [1:0]      req_ready_q;
  logic            rw_q, id_q;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q, wdata_q;
  logic [7:0]      rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;
  logic            grant_en, gnt_id;
  logic [1:0]      gnt;
  logic            in_cmd;

  // Only grant while idle and not already pulsing req_ready for a grant.
  assign grant_en = (state_q == ST_IDLE) && (req_ready_q == 2'b00);

  i2c_rr_arb2 u_arb (
    .clk    (scl_4x),
    .rst_n  (rst_n),
    .en     (grant_en),
    .req    (req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign in_cmd      = !(state_q inside {ST_IDLE, ST_RESP});
  assign wdog_inc    = wdog_q + 1'b1;
  assign timeout_hit = in_cmd && (wdog_inc == WDW'(TIMEOUT));

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d    = state_q;
    cmd_wait_d = cmd_wait_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    cmd_byte   = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_en && (|req_valid)) begin
          rdata_d = 8'h00;
          err_d   = ERR_OK;
        end
        if (req_ready_q != 2'b00) state_d = ST_ADDR;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        cmd_valid = !cmd_wait_q;
        unique case (state_q)
          ST_ADDR:   begin cmd_op = OP_START_WR;  cmd_byte = {dev_q, 1'b0}; end
          ST_REG:    begin cmd_op = OP_WRITE;     cmd_byte = reg_q;         end
          ST_DATA:   begin cmd_op = OP_WRITE;     cmd_byte = wdata_q;       end
          ST_RSTART: begin cmd_op = OP_START_WR;  cmd_byte = {dev_q, 1'b1}; end
          ST_READ:   begin cmd_op = OP_READ_NACK; cmd_byte = 8'h00;         end
          default:   begin cmd_op = OP_STOP;      cmd_byte = 8'h00;         end
        endcase

        if (!cmd_wait_q) begin
          if (cmd_ready) cmd_wait_d = 1'b1;
        end else if (cmd_done) begin
          cmd_wait_d = 1'b0;
          unique case (state_q)
            ST_ADDR: begin
              if (done_nack) begin err_d = ERR_DEV_NACK; state_d = ST_STOP; end
              else state_d = ST_REG;
            end
            ST_REG: begin
              if (done_nack) begin err_d = ERR_DATA_NACK; state_d = ST_STOP; end
              else state_d = rw_q ? ST_RSTART : ST_DATA;
            end
            ST_DATA: begin
              if (done_nack) err_d = ERR_DATA_NACK;
              state_d = ST_STOP;
            end
            ST_RSTART: begin
              if (done_nack) begin err_d = ERR_DEV_NACK; state_d = ST_STOP; end
              else state_d = ST_READ;
            end
            ST_READ: begin
              rdata_d = done_rdata;
              state_d = ST_STOP;
            end
            default: state_d = ST_RESP;
          endcase
        end

        // Watchdog wins over a same-cycle completion only if that completion
        // was not accepted; an expired command skips STOP entirely.
        if (timeout_hit && !(cmd_wait_q && cmd_done)) begin
          err_d      = ERR_TIMEOUT;
          cmd_wait_d = 1'b0;
          state_d    = ST_RESP;
        end
      end
    endcase
  end

  always_ff @(posedge scl_4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_wait_q  <= 1'b0;
      wdog_q      <= '0;
      req_ready_q <= 2'b00;
      rw_q        <= 1'b0;
      id_q        <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      err_q       <= ERR_OK;
    end else begin
      state_q     <= state_d;
      cmd_wait_q  <= cmd_wait_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= grant_en ? gnt : 2'b00;
      // The count restarts whenever a new command state is entered.
      if ((state_d != state_q) || !in_cmd) wdog_q <= '0;
      else                                 wdog_q <= wdog_inc;
      if (grant_en && (|req_valid)) begin
        id_q    <= gnt_id;
        rw_q    <= gnt_id ? req_rw[1]          : req_rw[0];
        dev_q   <= gnt_id ? req_dev_addr[13:7] : req_dev_addr[6:0];
        reg_q   <= gnt_id ? req_reg_addr[15:8] : req_reg_addr[7:0];
        wdata_q <= gnt_id ? req_wdata[15:8]    : req_wdata[7:0];
      end
    end
  end

endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 255, the maximum number of scl_4x cycles allowed per engine command.
REQ-002 scl_4x  in  1  the only clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  2  request pending, one bit per requester (bit 0 and bit 1).
REQ-005 req_ready  out  2  one-cycle pulse; the request is accepted when req_valid and req_ready are both high.
REQ-006 req_rw  in  2  per requester: 0 = write, 1 = read.
REQ-007 req_dev_addr  in  14  7-bit device address; [6:0] is requester 0, [13:7] is requester 1.
REQ-008 req_reg_addr  in  16  8-bit register address per requester, packed the same way.
REQ-009 req_wdata  in  16  8-bit write data per requester, packed the same way.
REQ-010 rsp_valid  out  1  response available; held until rsp_ready.
REQ-011 rsp_ready  in  1  the consumer accepts the response.
REQ-012 rsp_id  out  1  which requester owns the response.
REQ-013 rsp_rdata  out  8  read data (0 for writes).
REQ-014 rsp_err  out  2  00 = OK, 01 = device-address NACK, 10 = register/data NACK, 11 = timeout.
REQ-015 cmd_valid  out  1  command to the byte-level I2C engine.
REQ-016 cmd_ready  in  1  the engine accepts the command.
REQ-017 cmd_op  out  3  0 = START_WR (START, then write the byte), 1 = WRITE, 2 = READ_NACK, 3 = STOP.
REQ-018 cmd_byte  out  8  byte to transmit.
REQ-019 cmd_done  in  1  one-cycle pulse when the accepted command finishes.
REQ-020 done_nack  in  1  valid with cmd_done; 1 = the slave NACKed.
REQ-021 done_rdata  in  8  valid with cmd_done for READ_NACK.

Function
REQ-022 The FSM states SHALL be IDLE, ADDR, REG, DATA, RSTART, READ, STOP, RESP.
REQ-023 Arbitration in IDLE SHALL be round-robin between the two requesters.
- A single requester is granted.
- When both request, the one not granted last is granted.
- After reset, requester 0 wins a tie.
REQ-024 On grant, the block SHALL:
- pulse req_ready for that requester for one cycle;
- latch rw, dev_addr, reg_addr and wdata;
- go to ADDR on the next cycle.
REQ-025 Each command state SHALL run the same command handshake:
- assert cmd_valid with cmd_op and cmd_byte held stable until cmd_ready;
- then deassert cmd_valid;
- then wait for cmd_done, which is ignored at any other time.
REQ-026 The command sequence SHALL be:
- ADDR: START_WR with {dev,0}.
- REG: WRITE with reg_addr.
- Write path: DATA (WRITE wdata), then STOP.
- Read path: RSTART (START_WR with {dev,1}), then READ (READ_NACK, capture done_rdata), then STOP.
REQ-027 A NACK in ADDR or RSTART SHALL set err=01; a NACK in REG or DATA SHALL set err=10; either SHALL skip straight to STOP.
REQ-028 STOP SHALL issue the STOP command; its done_nack SHALL be ignored; on cmd_done the FSM SHALL go to RESP.
REQ-029 A watchdog counter SHALL clear on every command issue and increment each cycle until that command's cmd_done.
- When it reaches TIMEOUT: err=11, cmd_valid drops, and the FSM goes directly to RESP (no STOP).
REQ-030 RESP SHALL hold rsp_valid, rsp_id, rsp_rdata and rsp_err stable until rsp_ready, then return to IDLE.
- A new grant is possible in the cycle after the return to IDLE.
REQ-031 The requester latency SHALL be: req_ready one cycle after entering IDLE with req_valid high; cmd_valid asserted in the cycle after req_ready.
REQ-032 req_ready SHALL be 0 in every state except IDLE; a new request SHALL wait while a transaction is in flight.

Reset
REQ-033 While rst_n is low, the block SHALL hold:
- state = IDLE;
- all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, cmd_valid, cmd_op, cmd_byte);
- round-robin pointer = last granted 1;
- watchdog = 0.
REQ-034 A reset during a transaction SHALL abort it with no STOP issued and no response produced.

Structure
REQ-035 Package i2c_pkg SHALL hold:
- the cmd_op enum;
- the FSM state enum;
- the rsp_err codes;
- the default TIMEOUT.
REQ-036 The two-requester round-robin arbiter SHALL be a sub-module named i2c_rr_arb2.

Verification
REQ-037 Write: req0 (dev 0x08, reg 0x92, wdata 0xAC), all ACK -> commands START_WR 0x10, WRITE 0x92, WRITE 0xAC, STOP; response rsp_id=0, err=00.
REQ-038 Read: req1 (dev 0x08, reg 0x92), done_rdata=0x5A -> commands START_WR 0x10, WRITE 0x92, START_WR 0x11, READ_NACK, STOP; response rsp_rdata=0x5A, err=00.
REQ-039 Contention: both requesters held valid for three transactions -> grants 0, 1, 0; req_ready never high for both bits at once.
REQ-040 NACK: done_nack=1 on the ADDR command -> the next command is STOP; err=01; REG never issued.
REQ-041 Timeout with TIMEOUT=16: cmd_done withheld after REG accept -> err=11 exactly 16 cycles after issue; no STOP command.
REQ-042 Reset mid-READ: rst_n low -> cmd_valid=0 and rsp_valid=0 immediately; after release, req0 wins a tie.
